wb_port_arbiter: RTL and testbench

//   Owns the single register-file write port at the end of the pipeline. Arbitrates between the
//   in-order WriteBack result (ALU or load data) and an out-of-order multicycle (mul/div) result.
//   Mul/div results are buffered in a small FIFO and drained in idle WB slots. A starvation timer

---
 rtl/wb_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Purpose : owns the single register-file write port; merges in-order WB results with buffered mul/div results.
// Latency : a write selected in cycle t is presented on orf_* in cycle t+1 for exactly one cycle.
// Backpr. : mul/div side is valid/ready (ready = FIFO not full, pre-pop); WB side is stalled one cycle by owb_stall.
//
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   iwb_valid/iwb_rd/iwb_data       in-order WriteBack result (always wins the port outside FORCE)
//   owb_stall                       registered; high only during the forced-drain cycle
//   imd_valid/imd_rd/imd_data       mul/div result offer; omd_ready accepts it into the pending FIFO
//   orf_we/orf_waddr/orf_wdata      registered register-file write port
//   iquery_rd/oquery_pending        combinational scoreboard lookup over live FIFO entries
//   ofifo_count                     number of live FIFO entries
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iwb_valid,
    input  logic [ADDR_W-1:0] iwb_rd,
    input  logic [DATA_W-1:0] iwb_data,
    output logic              owb_stall,
    input  logic              imd_valid,
    input  logic [ADDR_W-1:0] imd_rd,
    input  logic [DATA_W-1:0] imd_data,
    output logic              omd_ready,
    output logic              orf_we,
    output logic [ADDR_W-1:0] orf_waddr,
    output logic [DATA_W-1:0] orf_wdata,
    input  logic [ADDR_W-1:0] iquery_rd,
    output logic              oquery_pending,
    output logic [CNT_W-1:0]  ofifo_count
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } md_ent_t;

    state_t            state_q, nxt_state;
    md_ent_t           ent_q   [DEPTH];
    md_ent_t           nxt_ent [DEPTH];
    logic [CNT_W-1:0]  count_q, nxt_count;
    logic [WAIT_W-1:0] wait_q, nxt_wait;
    logic [DEPTH-1:0]  live;

    logic              wb_take;     // WB owns the port this cycle (ignored during FORCE)
    logic              wb_we;       // WB write that actually reaches the regfile (rd != 0)
    logic              pop;
    logic              push;
    logic              head_killed;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // The FIFO is kept compacted with the head in slot 0, so liveness is a thermometer of count_q.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = (count_q > CNT_W'(i));
        end
    end

    assign omd_ready   = (count_q < CNT_W'(DEPTH));
    assign ofifo_count = count_q;

    always_comb begin
        oquery_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (ent_q[i].rd == iquery_rd)) begin
                oquery_pending = 1'b1;
            end
        end
        if (iquery_rd == '0) begin
            oquery_pending = 1'b0;
        end
    end

    assign wb_take     = iwb_valid && (state_q != S_FORCE);
    assign wb_we       = wb_take && (iwb_rd != '0);
    // Pops only happen when WB leaves the slot free, so a pop and a kill never hit the head together.
    assign pop         = (state_q == S_FORCE) || ((state_q == S_PEND) && !iwb_valid);
    // rd=0 offers complete the handshake but are dropped rather than enqueued.
    assign push        = imd_valid && omd_ready && (imd_rd != '0);
    assign head_killed = wb_we && live[0] && (ent_q[0].rd == iwb_rd);

    // Next FIFO contents: survivors (not popped, not killed by a younger WB write) in order, then the push.
    always_comb begin
        nxt_ent   = ent_q;
        nxt_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && !(pop && (i == 0)) && !(wb_we && (ent_q[i].rd == iwb_rd))) begin
                nxt_ent[nxt_count[IDX_W-1:0]] = ent_q[i];
                nxt_count = nxt_count + CNT_W'(1);
            end
        end
        if (push) begin
            nxt_ent[nxt_count[IDX_W-1:0]] = '{rd: imd_rd, data: imd_data};
            nxt_count = nxt_count + CNT_W'(1);
        end
    end

    // Wait counter tracks how long the current head has been held off by WB traffic.
    always_comb begin
        nxt_wait = '0;
        if ((state_q == S_PEND) && iwb_valid && !head_killed) begin
            nxt_wait = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
        end
        if (nxt_count == '0) begin
            nxt_wait = '0;
        end
    end

    always_comb begin
        if (nxt_count == '0) begin
            nxt_state = S_IDLE;
        end else if ((state_q == S_PEND) && (nxt_wait == WAIT_W'(MAX_WAIT))) begin
            nxt_state = S_FORCE;
        end else begin
            nxt_state = S_PEND;
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = iwb_rd;
        sel_data = iwb_data;
        if (pop) begin
            sel_we   = 1'b1;
            sel_addr = ent_q[0].rd;
            sel_data = ent_q[0].data;
        end else if (wb_we) begin
            sel_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            wait_q    <= '0;
            owb_stall <= 1'b0;
            orf_we    <= 1'b0;
            orf_waddr <= '0;
            orf_wdata <= '0;
        end else begin
            state_q   <= nxt_state;
            count_q   <= nxt_count;
            wait_q    <= nxt_wait;
            ent_q     <= nxt_ent;
            owb_stall <= (nxt_state == S_FORCE);
            orf_we    <= sel_we;
            if (sel_we) begin
                orf_waddr <= sel_addr;
                orf_wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              iwb_valid;
    logic [ADDR_W-1:0] iwb_rd;
    logic [DATA_W-1:0] iwb_data;
    logic              owb_stall;
    logic              imd_valid;
    logic [ADDR_W-1:0] imd_rd;
    logic [DATA_W-1:0] imd_data;
    logic              omd_ready;
    logic              orf_we;
    logic [ADDR_W-1:0] orf_waddr;
    logic [DATA_W-1:0] orf_wdata;
    logic [ADDR_W-1:0] iquery_rd;
    logic              oquery_pending;
    logic [CNT_W-1:0]  ofifo_count;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .iwb_valid(iwb_valid), .iwb_rd(iwb_rd), .iwb_data(iwb_data),
        .owb_stall(owb_stall),
        .imd_valid(imd_valid), .imd_rd(imd_rd), .imd_data(imd_data),
        .omd_ready(omd_ready),
        .orf_we(orf_we), .orf_waddr(orf_waddr), .orf_wdata(orf_wdata),
        .iquery_rd(iquery_rd), .oquery_pending(oquery_pending),
        .ofifo_count(ofifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; iwb_valid = 1'b0; iwb_rd = '0; iwb_data = '0;
        imd_valid = 1'b1; imd_rd = 5'd5; imd_data = 32'h1234; iquery_rd = '0;

        // 1. Reset dominates an offered mul/div result
        tick(); tick();
        chk("rst_we", orf_we, 0);
        chk("rst_stall", owb_stall, 0);
        chk("rst_count", ofifo_count, 0);
        rstn = 1'b1; imd_valid = 1'b0; #1;
        chk("rst_ready", omd_ready, 1);

        // 2. Idle drain: written two edges after the push
        imd_valid = 1'b1; imd_rd = 5'd5; imd_data = 32'hDEAD;
        tick();
        imd_valid = 1'b0;
        chk("idle_count1", ofifo_count, 1);
        chk("idle_we0", orf_we, 0);
        tick();
        chk("idle_we", orf_we, 1);
        chk("idle_addr", orf_waddr, 5);
        chk("idle_data", orf_wdata, 32'hDEAD);
        chk("idle_count0", ofifo_count, 0);
        tick();
        chk("idle_we_after", orf_we, 0);

        // 3. Priority and forced drain
        iwb_valid = 1'b1; iwb_rd = 5'd3; iwb_data = 32'h33;
        imd_valid = 1'b1; imd_rd = 5'd7; imd_data = 32'h77;
        tick();
        imd_valid = 1'b0;
        chk("prio_addr0", orf_waddr, 3);
        chk("prio_count", ofifo_count, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("prio_we", orf_we, 1);
            chk("prio_addr", orf_waddr, 3);
            chk("prio_stall", owb_stall, (i == 3) ? 1 : 0);
        end
        tick();
        chk("force_we", orf_we, 1);
        chk("force_addr", orf_waddr, 7);
        chk("force_data", orf_wdata, 32'h77);
        chk("force_stall_off", owb_stall, 0);
        chk("force_count", ofifo_count, 0);
        tick();
        chk("reissue_addr", orf_waddr, 3);
        chk("reissue_data", orf_wdata, 32'h33);

        // 4. Full FIFO holds the third offer, order preserved on drain
        imd_valid = 1'b1; imd_rd = 5'd1; imd_data = 32'h101;
        tick();
        imd_rd = 5'd2; imd_data = 32'h202;
        tick();
        chk("full_count", ofifo_count, 2);
        chk("full_ready", omd_ready, 0);
        imd_rd = 5'd6; imd_data = 32'h606;
        tick();
        chk("full_hold_count", ofifo_count, 2);
        chk("full_hold_ready", omd_ready, 0);
        iwb_valid = 1'b0;
        tick();
        chk("drain1_addr", orf_waddr, 1);
        chk("drain1_data", orf_wdata, 32'h101);
        chk("drain1_count", ofifo_count, 1);
        chk("drain1_ready", omd_ready, 1);
        tick();
        imd_valid = 1'b0;
        chk("drain2_addr", orf_waddr, 2);
        chk("drain2_count", ofifo_count, 1);
        tick();
        chk("drain3_we", orf_we, 1);
        chk("drain3_addr", orf_waddr, 6);
        chk("drain3_data", orf_wdata, 32'h606);
        chk("drain3_count", ofifo_count, 0);

        // 5. Younger WB write kills the pending entry
        iwb_valid = 1'b1; iwb_rd = 5'd3; iwb_data = 32'h33;
        imd_valid = 1'b1; imd_rd = 5'd9; imd_data = 32'h1111;
        tick();
        imd_valid = 1'b0; iquery_rd = 5'd9; #1;
        chk("kill_query_before", oquery_pending, 1);
        iwb_rd = 5'd9; iwb_data = 32'h2222;
        tick();
        chk("kill_addr", orf_waddr, 9);
        chk("kill_data", orf_wdata, 32'h2222);
        chk("kill_count", ofifo_count, 0);
        chk("kill_query_after", oquery_pending, 0);
        iwb_valid = 1'b0;
        tick();
        chk("kill_no_write1", orf_we, 0);
        tick();
        chk("kill_no_write2", orf_we, 0);

        // 6. $0 handling and scoreboard query
        iwb_valid = 1'b1; iwb_rd = 5'd0; iwb_data = 32'h55;
        tick();
        chk("zero_wb_we", orf_we, 0);
        iwb_valid = 1'b0; imd_valid = 1'b1; imd_rd = 5'd0; imd_data = 32'h66;
        tick();
        imd_valid = 1'b0;
        chk("zero_md_count", ofifo_count, 0);
        chk("zero_md_we", orf_we, 0);
        iwb_valid = 1'b1; iwb_rd = 5'd3;
        imd_valid = 1'b1; imd_rd = 5'd4; imd_data = 32'h44;
        tick();
        imd_valid = 1'b0; iquery_rd = 5'd4; #1;
        chk("query4", oquery_pending, 1);
        iquery_rd = 5'd0; #1;
        chk("query0", oquery_pending, 0);
        iquery_rd = 5'd5; #1;
        chk("query5", oquery_pending, 0);

        // Reset mid-operation discards the pending write
        rstn = 1'b0; iwb_valid = 1'b0;
        tick();
        chk("midrst_count", ofifo_count, 0);
        chk("midrst_we", orf_we, 0);
        chk("midrst_stall", owb_stall, 0);
        rstn = 1'b1;
        tick();
        chk("midrst_no_write", orf_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
